// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Summary  : 4x4 matrix keypad scanner with debounce, key decode and
//            packed-BCD operand assembly for the calculator datapath.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MAX_DIGITS      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] num,
    output logic [2:0]  digit_count,
    output logic        num_valid
);

    localparam int c_CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]         c_MAX_DIG   = 3'(MAX_DIGITS);

    localparam logic [3:0] c_KEY_STAR = 4'hE;
    localparam logic [3:0] c_KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_col_meta;
    logic [3:0]           r_col_s;
    logic [3:0]           r_row;
    logic [1:0]           r_row_idx;
    logic [1:0]           r_key_row;
    logic [1:0]           r_key_col;
    logic                 r_key_valid;
    logic [3:0]           r_key_code;
    logic [15:0]          r_num;
    logic [2:0]           r_digit_count;
    logic                 r_num_valid;
    logic                 r_done;

    logic [1:0]           w_low_col;
    logic [15:0]          w_base_num;
    logic [2:0]           w_base_cnt;

    function automatic logic [3:0] f_decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Columns are pulled up, so the idle synchronizer value is all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= col;
            r_col_s    <= r_col_meta;
        end
    end

    always_comb begin
        w_low_col = 2'd3;
        if (!r_col_s[0])      w_low_col = 2'd0;
        else if (!r_col_s[1]) w_low_col = 2'd1;
        else if (!r_col_s[2]) w_low_col = 2'd2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SCAN;
            r_cnt       <= c_CNT_ZERO;
            r_row       <= 4'b1110;
            r_row_idx   <= 2'd0;
            r_key_row   <= 2'd0;
            r_key_col   <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_cnt == c_SCAN_LAST) begin
                        r_cnt <= c_CNT_ZERO;
                        if (r_col_s != 4'hF) begin
                            r_key_row <= r_row_idx;
                            r_key_col <= w_low_col;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            r_row     <= {r_row[2:0], r_row[3]};
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    // A bounce back high abandons the press; the same row is rescanned.
                    if (r_col_s[r_key_col]) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= ST_SCAN;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= ST_PRESSED;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= f_decode(r_key_row, r_key_col);
                    r_cnt       <= c_CNT_ZERO;
                    r_state     <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (r_col_s != 4'hF) begin
                        r_cnt <= c_CNT_ZERO;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_cnt     <= c_CNT_ZERO;
                        r_state   <= ST_SCAN;
                        r_row_idx <= r_row_idx + 2'd1;
                        r_row     <= {r_row[2:0], r_row[3]};
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= c_CNT_ZERO;
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    // A digit after a completed operand starts a fresh one.
    assign w_base_num = r_done ? 16'h0000 : r_num;
    assign w_base_cnt = r_done ? 3'd0     : r_digit_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num         <= 16'h0000;
            r_digit_count <= 3'd0;
            r_num_valid   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_num_valid <= 1'b0;
            if (r_key_valid) begin
                if (r_key_code <= 4'h9) begin
                    r_done <= 1'b0;
                    if (w_base_cnt < c_MAX_DIG) begin
                        r_num         <= {w_base_num[11:0], r_key_code};
                        r_digit_count <= w_base_cnt + 3'd1;
                    end else begin
                        r_num         <= w_base_num;
                        r_digit_count <= w_base_cnt;
                    end
                end else if (r_key_code == c_KEY_STAR) begin
                    r_num         <= 16'h0000;
                    r_digit_count <= 3'd0;
                    r_done        <= 1'b0;
                end else if (r_key_code == c_KEY_HASH) begin
                    if ((r_digit_count != 3'd0) && !r_done) begin
                        r_num_valid <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
            end
        end
    end

    assign row         = r_row;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign num         = r_num;
    assign digit_count = r_digit_count;
    assign num_valid   = r_num_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Summary  : Directed-vector bench for keypad_entry with a behavioural keypad.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] num;
    logic [2:0]  digit_count;
    logic        num_valid;

    logic        key_on;
    logic        glitch;
    int          key_r;
    int          key_c;

    int          tests;
    int          fails;
    int          kv_cnt;
    int          nv_cnt;
    logic [3:0]  last_code;
    logic [15:0] nv_num;

    typedef struct {
        logic [3:0]  code;
        int          hold;
        logic [15:0] exp_num;
        logic [2:0]  exp_cnt;
        int          exp_nv;
    } vec_t;

    vec_t       vecs[17];
    logic [3:0] keymap[4][4];

    keypad_entry #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .MAX_DIGITS      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .num         (num),
        .digit_count (digit_count),
        .num_valid   (num_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key shorts its column to the driven row; the glitch pulls col[0] regardless.
    always_comb begin
        col = 4'hF;
        if (key_on && (row[key_r] == 1'b0)) col[key_c] = 1'b0;
        if (glitch) col[0] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt    = kv_cnt + 1;
            last_code = key_code;
        end
        if (num_valid) begin
            nv_cnt = nv_cnt + 1;
            nv_num = num;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] target, input logic eq, input int budget,
                            input string name);
        int n;
        n = 0;
        while (((row == target) != eq) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (row == target)}, {31'd0, eq});
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == code) begin
                    key_r = r;
                    key_c = c;
                end
        key_on = 1'b1;
        repeat (hold) @(negedge clk);
        key_on = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv0;
        int nv0;
        tests = 0; fails = 0; kv_cnt = 0; nv_cnt = 0;
        last_code = 4'h0; nv_num = 16'h0;
        rst = 1'b0; key_on = 1'b0; glitch = 1'b0; key_r = 0; key_c = 0;

        keymap[0][0] = 4'h1; keymap[0][1] = 4'h2; keymap[0][2] = 4'h3; keymap[0][3] = 4'hA;
        keymap[1][0] = 4'h4; keymap[1][1] = 4'h5; keymap[1][2] = 4'h6; keymap[1][3] = 4'hB;
        keymap[2][0] = 4'h7; keymap[2][1] = 4'h8; keymap[2][2] = 4'h9; keymap[2][3] = 4'hC;
        keymap[3][0] = 4'hE; keymap[3][1] = 4'h0; keymap[3][2] = 4'hF; keymap[3][3] = 4'hD;

        vecs[0]  = '{4'h5, 40, 16'h0005, 3'd1, 0};
        vecs[1]  = '{4'hE, 60, 16'h0000, 3'd0, 0};
        vecs[2]  = '{4'h1, 60, 16'h0001, 3'd1, 0};
        vecs[3]  = '{4'h2, 60, 16'h0012, 3'd2, 0};
        vecs[4]  = '{4'h3, 60, 16'h0123, 3'd3, 0};
        vecs[5]  = '{4'h4, 60, 16'h0123, 3'd3, 0};
        vecs[6]  = '{4'hF, 60, 16'h0123, 3'd3, 1};
        vecs[7]  = '{4'hF, 60, 16'h0123, 3'd3, 0};
        vecs[8]  = '{4'h7, 60, 16'h0007, 3'd1, 0};
        vecs[9]  = '{4'hA, 60, 16'h0007, 3'd1, 0};
        vecs[10] = '{4'h9, 60, 16'h0079, 3'd2, 0};
        vecs[11] = '{4'hE, 60, 16'h0000, 3'd0, 0};
        vecs[12] = '{4'hF, 60, 16'h0000, 3'd0, 0};
        vecs[13] = '{4'h0, 60, 16'h0000, 3'd1, 0};
        vecs[14] = '{4'hF, 60, 16'h0000, 3'd1, 1};
        vecs[15] = '{4'hD, 60, 16'h0000, 3'd1, 0};
        vecs[16] = '{4'h6, 60, 16'h0006, 3'd1, 0};

        repeat (3) @(negedge clk);
        check("reset_row", {28'd0, row}, 32'hE);
        check("reset_key_valid", {31'd0, key_valid}, 32'd0);
        check("reset_key_code", {28'd0, key_code}, 32'd0);
        check("reset_num", {16'd0, num}, 32'd0);
        check("reset_digit_count", {29'd0, digit_count}, 32'd0);
        check("reset_num_valid", {31'd0, num_valid}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            kv0 = kv_cnt;
            nv0 = nv_cnt;
            press(vecs[i].code, vecs[i].hold);
            check($sformatf("v%0d_key_events", i), kv_cnt - kv0, 32'd1);
            check($sformatf("v%0d_key_code", i), {28'd0, last_code}, {28'd0, vecs[i].code});
            check($sformatf("v%0d_num", i), {16'd0, num}, {16'd0, vecs[i].exp_num});
            check($sformatf("v%0d_digit_count", i), {29'd0, digit_count},
                  {29'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d_num_valid_pulses", i), nv_cnt - nv0, vecs[i].exp_nv);
            if (vecs[i].exp_nv != 0)
                check($sformatf("v%0d_num_at_valid", i), {16'd0, nv_num},
                      {16'd0, vecs[i].exp_num});
        end

        // Short col[0] glitch while row 0 is driven must not produce a key.
        kv0 = kv_cnt;
        wait_row(4'b1110, 1'b0, 40, "glitch_wait_leave_row0");
        wait_row(4'b1110, 1'b1, 40, "glitch_wait_row0");
        glitch = 1'b1;
        repeat (5) @(negedge clk);
        glitch = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_row_held_for_debounce", {28'd0, row}, 32'hE);
        wait_row(4'b1101, 1'b1, 30, "glitch_row_advances");
        repeat (20) @(negedge clk);
        check("glitch_no_key_event", kv_cnt - kv0, 32'd0);

        // Hold '8', reset in the middle of its debounce, keep holding.
        wait_row(4'b1011, 1'b0, 40, "rst_wait_leave_row2");
        key_r = 2; key_c = 1; key_on = 1'b1;
        wait_row(4'b1011, 1'b1, 40, "rst_wait_row2");
        kv0 = kv_cnt;
        repeat (6) @(negedge clk);
        check("rst_no_event_before_reset", kv_cnt - kv0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_row", {28'd0, row}, 32'hE);
        check("rst_mid_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_mid_key_code", {28'd0, key_code}, 32'd0);
        check("rst_mid_num", {16'd0, num}, 32'd0);
        check("rst_mid_digit_count", {29'd0, digit_count}, 32'd0);
        check("rst_mid_num_valid", {31'd0, num_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        key_on = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_after_key_events", kv_cnt - kv0, 32'd1);
        check("rst_after_key_code", {28'd0, last_code}, 32'h8);
        check("rst_after_num", {16'd0, num}, 32'h0008);
        check("rst_after_digit_count", {29'd0, digit_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
# keypad_entry

Upstream input stage for the calculator datapath. Scans a 4×4 matrix keypad, synchronizes and debounces the column lines, and decodes each key press into a single event. It assembles decimal digits into a packed-BCD operand and presents the completed operand with a one-cycle valid pulse. The operand feeds the adder operand registers and, live, the seven-segment display driver.

## Interface
Parameters:
- SCAN_DIV, 16: clock cycles each row is driven before its columns are sampled. Must be ≥ 4.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press or a release.
- MAX_DIGITS, 3: maximum digits per operand, range 1–4.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- col  in  4  keypad columns, active-low, externally pulled up. Asynchronous to clk.
- row  out  4  keypad row drive, one-hot active-low.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key; valid with key_valid, held afterwards.
- num  out  16  packed BCD operand being entered, digit 0 in [3:0].
- digit_count  out  3  number of digits currently in num, 0..MAX_DIGITS.
- num_valid  out  1  one-cycle pulse; num is a completed operand.

## Operation
- **Key map** (row, col → key_code):
  - r0: 1, 2, 3, A → 0x1, 0x2, 0x3, 0xA
  - r1: 4, 5, 6, B → 0x4, 0x5, 0x6, 0xB
  - r2: 7, 8, 9, C → 0x7, 0x8, 0x9, 0xC
  - r3: *, 0, #, D → 0xE, 0x0, 0xF, 0xD
- **Column synchronizer:** col passes through a 2-flop synchronizer (col_s). All decisions use col_s.
- **FSM states:** SCAN, DEBOUNCE, PRESSED, RELEASE.
  - SCAN: drive the current row. After SCAN_DIV cycles, sample col_s.
    - If col_s ≠ 4'hF: latch the row and the lowest-index low column, then go to DEBOUNCE.
    - Otherwise advance the row (3 wraps to 0) and restart the dwell counter.
  - DEBOUNCE: row held. Count cycles while the latched column stays low.
    - If the latched column goes high, return to SCAN at the same row with the counter cleared.
    - When the count reaches DEBOUNCE_CYCLES, go to PRESSED.
  - PRESSED: lasts one cycle. Asserts key_valid and drives key_code. Go to RELEASE.
  - RELEASE: row held. Count consecutive cycles with col_s == 4'hF. Any low column restarts the count.
    - At DEBOUNCE_CYCLES, go to SCAN on the next row.
    - A held key never produces a second event.
- **Operand assembly** (applied in the cycle after key_valid):
  - Digit 0x0–0x9:
    - If a completed operand is pending (done flag set), first clear num, clear digit_count, and clear done.
    - If digit_count < MAX_DIGITS: num ← {num[11:0], digit}, digit_count + 1.
    - Otherwise the digit is ignored.
  - '*' (0xE): num ← 0, digit_count ← 0, done ← 0.
  - '#' (0xF):
    - If digit_count > 0 and done is clear: pulse num_valid for one cycle, set done, and hold num.
    - Otherwise ignored, with no pulse.
  - 0xA–0xD: no effect on num. They are still reported via key_valid.
- **Reset values:** row = 4'b1110, key_valid = 0, key_code = 0, num = 0, digit_count = 0, num_valid = 0, done = 0, FSM = SCAN, and all counters and synchronizer flops = 0 / 1 (col sync flops = 1).
- **Reset mid-operation:** asserting rst in any state returns all state to the reset values immediately (asynchronously). A key still held when rst deasserts is detected on its row's next scan and debounced afresh.

## Timing
- Row dwell is SCAN_DIV cycles, so a full scan is 4·SCAN_DIV cycles.
- Press-to-event latency: from the first col_s low sample in SCAN, key_valid rises DEBOUNCE_CYCLES + 1 cycles later.
- num, digit_count, and num_valid update 1 cycle after key_valid.
- num_valid is high for exactly 1 cycle. num is stable during that cycle and afterwards until the next digit or '*'.
- Minimum accepted inter-press spacing is roughly 2·DEBOUNCE_CYCLES + 4·SCAN_DIV cycles.

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE_CYCLES = 8.

- Hold '5' (row 1, col 1 low) for 40 cycles, then release → exactly one key_valid with key_code = 0x5; num = 0x0005, digit_count = 1.
- Press 1, 2, 3, 4 in sequence → num = 0x0123 and digit_count = 3. The '4' still produces key_valid, but num is unchanged.
- After the previous scenario, press '#' → num_valid pulses 1 cycle with num = 0x0123. A second '#' produces no pulse. Then press '7' → num = 0x0007, digit_count = 1.
- Glitch col[0] low for 5 cycles on row 0 → no key_valid; FSM returns to SCAN and row advances normally.
- Press '9', then '*' → num = 0x0000, digit_count = 0. Press '#' → no num_valid.
- Hold '8', assert rst low mid-DEBOUNCE for 3 cycles, keep holding → outputs at reset values while rst is low; after release of rst, exactly one key_valid with key_code = 0x8.
